// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the f2h_sdram0 read-port arbiter.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam int REQ_DISP = 0;
  localparam int REQ_ANLZ = 1;

  localparam int DEF_ADDR_W  = 29;
  localparam int DEF_DATA_W  = 64;
  localparam int DEF_BURST_W = 8;

endpackage

// File: rtl/sdram_rd_arbiter_if.sv
// Avalon-MM burst read bundle; master drives the command, slave returns data.
interface sdram_rd_arbiter_if
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int BURST_W = DEF_BURST_W
) ();

  logic [ADDR_W-1:0]  address;
  logic [BURST_W-1:0] burstcount;
  logic               read;
  logic               waitrequest;
  logic [DATA_W-1:0]  readdata;
  logic               readdatavalid;

  modport master (
    output address, burstcount, read,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, burstcount, read,
    output waitrequest, readdata, readdatavalid
  );

endinterface

// File: rtl/sdram_arb_pick.sv
// Winner select between display (m0) and analyzer (m1) with urgency priority,
// a starvation limit for m1 and round-robin otherwise.
module sdram_arb_pick
  import sdram_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clk_w,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_urgent,
  input  logic       i_update,
  output logic       o_winner,
  output logic       o_valid
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] r_starve_cnt;
  logic       r_last_grant;
  logic       w_both;
  logic       w_winner;

  always_comb begin
    w_both   = &i_req;
    w_winner = 1'(REQ_DISP);
    if (w_both) begin
      if (i_urgent) begin
        w_winner = (r_starve_cnt < LIMIT) ? 1'(REQ_DISP) : 1'(REQ_ANLZ);
      end else begin
        w_winner = ~r_last_grant;
      end
    end else if (i_req[REQ_ANLZ]) begin
      w_winner = 1'(REQ_ANLZ);
    end
  end

  assign o_winner = w_winner;
  assign o_valid  = |i_req;

  // Only urgent wins over a waiting m1 count toward starvation
  always_ff @(posedge clk_w or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= 4'd0;
      r_last_grant <= 1'(REQ_ANLZ);
    end else if (i_update && o_valid) begin
      r_last_grant <= w_winner;
      if (w_winner == 1'(REQ_ANLZ)) begin
        r_starve_cnt <= 4'd0;
      end else if (w_both && i_urgent && (r_starve_cnt < LIMIT)) begin
        r_starve_cnt <= r_starve_cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/sdram_rd_arbiter.sv
// Shares the f2h_sdram0 burst read port between display and analyzer DMAs,
// one burst outstanding at a time.
module sdram_rd_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int BURST_W      = DEF_BURST_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk_w,
  input  logic                rst_n,
  sdram_rd_arbiter_if.slave   m0,
  sdram_rd_arbiter_if.slave   m1,
  input  logic                m0_urgent,
  sdram_rd_arbiter_if.master  sdram0,
  output logic                busy
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_grant;
  logic [ADDR_W-1:0]  r_addr;
  logic [BURST_W-1:0] r_burst;
  logic               r_read;
  logic [BURST_W:0]   r_beat_cnt;

  logic               w_winner;
  logic               w_win_valid;
  logic               w_accept;
  logic               w_beat;
  logic               w_last_beat;
  logic [BURST_W:0]   w_beat_nxt;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [BURST_W-1:0] w_sel_burst_raw;
  logic [BURST_W-1:0] w_sel_burst;
  logic [DATA_W-1:0]  w_rdata;
  logic [1:0]         w_req;

  assign w_req[REQ_DISP] = m0.read;
  assign w_req[REQ_ANLZ] = m1.read;

  sdram_arb_pick #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_pick (
    .clk_w    (clk_w),
    .rst_n    (rst_n),
    .i_req    (w_req),
    .i_urgent (m0_urgent),
    .i_update (r_state == IDLE),
    .o_winner (w_winner),
    .o_valid  (w_win_valid)
  );

  assign w_sel_addr      = (w_winner == 1'(REQ_ANLZ)) ? m1.address : m0.address;
  assign w_sel_burst_raw = (w_winner == 1'(REQ_ANLZ)) ? m1.burstcount : m0.burstcount;
  assign w_sel_burst     = (w_sel_burst_raw == '0) ? BURST_W'(1) : w_sel_burst_raw;

  assign w_accept    = (r_state == CMD) && !sdram0.waitrequest;
  assign w_beat      = (r_state == DATA) && sdram0.readdatavalid;
  assign w_beat_nxt  = r_beat_cnt + {{BURST_W{1'b0}}, 1'b1};
  assign w_last_beat = w_beat && (w_beat_nxt == {1'b0, r_burst});

  always_ff @(posedge clk_w or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_win_valid)         w_state_nxt = CMD;
      CMD:     if (!sdram0.waitrequest) w_state_nxt = DATA;
      DATA:    if (w_last_beat)         w_state_nxt = IDLE;
      default:                          w_state_nxt = IDLE;
    endcase
  end

  // Command fields are captured once in IDLE; requesters may change theirs afterwards
  always_ff @(posedge clk_w or negedge rst_n) begin
    if (!rst_n) begin
      r_grant    <= 1'(REQ_DISP);
      r_addr     <= '0;
      r_burst    <= '0;
      r_read     <= 1'b0;
      r_beat_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_win_valid) begin
            r_grant <= w_winner;
            r_addr  <= w_sel_addr;
            r_burst <= w_sel_burst;
            r_read  <= 1'b1;
          end
        end
        CMD: begin
          if (w_accept) begin
            r_read     <= 1'b0;
            r_beat_cnt <= '0;
          end
        end
        DATA: begin
          if (w_beat) begin
            r_beat_cnt <= w_beat_nxt;
          end
        end
        default: begin
          r_read <= 1'b0;
        end
      endcase
    end
  end

  assign sdram0.address    = r_addr;
  assign sdram0.burstcount = r_burst;
  assign sdram0.read       = r_read;

  // Acceptance and data valid pass straight through so requesters see them in the slave's cycle
  assign w_rdata          = sdram0.readdata;
  assign m0.readdata      = w_rdata;
  assign m1.readdata      = w_rdata;
  assign m0.waitrequest   = !(w_accept && (r_grant == 1'(REQ_DISP)));
  assign m1.waitrequest   = !(w_accept && (r_grant == 1'(REQ_ANLZ)));
  assign m0.readdatavalid = w_beat && (r_grant == 1'(REQ_DISP));
  assign m1.readdatavalid = w_beat && (r_grant == 1'(REQ_ANLZ));

  assign busy = (r_state != IDLE);

endmodule
